// File: rtl/led_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : led_scan_scheduler
// Brief    : Row scan sequencer for the LED matrix driver. Each row gets a
//            blanking gap followed by a dwell period. Digits are loaded into a
//            pending buffer and swapped into the display at frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module led_scan_scheduler #(
  parameter int ROWS  = 8,
  parameter int DWELL = 2500,
  parameter int BLANK = 50
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    load_valid,
  input  logic [15:0]             load_digits,
  output logic                    load_ready,
  output logic [15:0]             digits_out,
  output logic [$clog2(ROWS)-1:0] cur_row,
  output logic                    row_active,
  output logic                    frame_start
);

  localparam int c_ROW_W   = $clog2(ROWS);
  localparam int c_DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int c_BLANK_W = (BLANK > 1) ? $clog2(BLANK) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_BLANK_W-1:0]   r_blank_cnt;
  logic [c_BLANK_W-1:0]   w_blank_cnt_nxt;
  logic [c_DWELL_W-1:0]   r_dwell_cnt;
  logic [c_DWELL_W-1:0]   w_dwell_cnt_nxt;
  logic [c_ROW_W-1:0]     r_cur_row;
  logic [c_ROW_W-1:0]     w_cur_row_nxt;
  logic                   r_row_active;
  logic                   r_frame_start;
  logic                   w_frame_start_nxt;
  logic [15:0]            r_pending;
  logic                   r_pending_full;
  logic [15:0]            r_digits;
  logic                   w_blank_done;
  logic                   w_dwell_done;
  logic                   w_last_row;
  logic                   w_frame_edge;

  assign w_blank_done = (r_blank_cnt == c_BLANK_W'(BLANK - 1));
  assign w_dwell_done = (r_dwell_cnt == c_DWELL_W'(DWELL - 1));
  assign w_last_row   = (r_cur_row == c_ROW_W'(ROWS - 1));
  // Idle counts as a boundary so loads made while the display is off show up at once.
  assign w_frame_edge = (r_state == S_IDLE) ||
                        ((r_state == S_DRIVE) && w_dwell_done && w_last_row);

  always_comb begin
    w_state_nxt       = r_state;
    w_blank_cnt_nxt   = r_blank_cnt;
    w_dwell_cnt_nxt   = r_dwell_cnt;
    w_cur_row_nxt     = r_cur_row;
    w_frame_start_nxt = 1'b0;
    if (!enable) begin
      w_state_nxt     = S_IDLE;
      w_blank_cnt_nxt = '0;
      w_dwell_cnt_nxt = '0;
      w_cur_row_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt     = S_BLANK;
          w_blank_cnt_nxt = '0;
          w_dwell_cnt_nxt = '0;
          w_cur_row_nxt   = '0;
        end
        S_BLANK: begin
          if (w_blank_done) begin
            w_state_nxt       = S_DRIVE;
            w_blank_cnt_nxt   = '0;
            w_frame_start_nxt = (r_cur_row == '0);
          end else begin
            w_blank_cnt_nxt = r_blank_cnt + 1'b1;
          end
        end
        S_DRIVE: begin
          if (w_dwell_done) begin
            w_state_nxt     = S_BLANK;
            w_dwell_cnt_nxt = '0;
            w_cur_row_nxt   = w_last_row ? '0 : r_cur_row + 1'b1;
          end else begin
            w_dwell_cnt_nxt = r_dwell_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt     = S_IDLE;
          w_blank_cnt_nxt = '0;
          w_dwell_cnt_nxt = '0;
          w_cur_row_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_blank_cnt    <= '0;
      r_dwell_cnt    <= '0;
      r_cur_row      <= '0;
      r_row_active   <= 1'b0;
      r_frame_start  <= 1'b0;
      r_pending      <= '0;
      r_pending_full <= 1'b0;
      r_digits       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_blank_cnt   <= w_blank_cnt_nxt;
      r_dwell_cnt   <= w_dwell_cnt_nxt;
      r_cur_row     <= w_cur_row_nxt;
      r_row_active  <= (w_state_nxt == S_DRIVE);
      r_frame_start <= w_frame_start_nxt;
      // Accept requires an empty buffer, so it can never coincide with a swap.
      if (r_pending_full && w_frame_edge) begin
        r_digits       <= r_pending;
        r_pending_full <= 1'b0;
      end else if (load_valid && load_ready) begin
        r_pending      <= load_digits;
        r_pending_full <= 1'b1;
      end
    end
  end

  assign load_ready  = resetn & ~r_pending_full;
  assign digits_out  = r_digits;
  assign cur_row     = r_cur_row;
  assign row_active  = r_row_active;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_led_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_scan_scheduler
// Brief    : Directed and randomized bench; a scan-position model predicts
//            every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_scan_scheduler;

  localparam int ROWS   = 4;
  localparam int DWELL  = 4;
  localparam int BLANK  = 2;
  localparam int PERIOD = BLANK + DWELL;
  localparam int FRAME  = ROWS * PERIOD;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic        enable;
  logic        load_valid;
  logic [15:0] load_digits;
  logic        load_ready;
  logic [15:0] digits_out;
  logic [1:0]  cur_row;
  logic        row_active;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  led_scan_scheduler #(.ROWS(ROWS), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .enable      (enable),
    .load_valid  (load_valid),
    .load_digits (load_digits),
    .load_ready  (load_ready),
    .digits_out  (digits_out),
    .cur_row     (cur_row),
    .row_active  (row_active),
    .frame_start (frame_start)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Model: m_pos is the cycle offset inside the frame (-1 while idle).
  bit          m_valid = 0;
  int          m_pos   = -1;
  logic [15:0] m_pend  = '0;
  logic [15:0] m_disp  = '0;
  bit          m_full  = 0;
  bit          m_acc   = 0;
  bit          m_bnd;

  always @(posedge CLOCK_50) begin
    if (!resetn) begin
      m_valid = 1;
      m_pos   = -1;
      m_pend  = '0;
      m_disp  = '0;
      m_full  = 0;
      m_acc   = 0;
    end else begin
      m_bnd = (m_pos < 0) || (m_pos == FRAME - 1);
      m_acc = load_valid && !m_full;
      if (m_full && m_bnd) begin
        m_disp = m_pend;
        m_full = 0;
      end else if (m_acc) begin
        m_pend = load_digits;
        m_full = 1;
      end
      if (!enable)        m_pos = -1;
      else if (m_pos < 0) m_pos = 0;
      else                m_pos = (m_pos + 1) % FRAME;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (m_valid) begin
      check("row_active", 32'(row_active), 32'((m_pos >= 0) && ((m_pos % PERIOD) >= BLANK)));
      check("cur_row", 32'(cur_row), (m_pos < 0) ? 32'd0 : 32'(m_pos / PERIOD));
      check("frame_start", 32'(frame_start), 32'(m_pos == BLANK));
      check("digits_out", 32'(digits_out), 32'(m_disp));
      check("load_ready", 32'(load_ready), 32'(resetn && !m_full));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_row(input int row);
    int n = 0;
    while (!(cur_row == 2'(row) && row_active) && n < 3 * FRAME) begin
      step();
      n++;
    end
    check("wait_row_bound", 32'(n < 3 * FRAME), 32'd1);
  endtask

  task automatic wait_digits(input logic [15:0] val, output int n);
    n = 0;
    while (digits_out !== val && n < 3 * FRAME) begin
      step();
      n++;
    end
    check("wait_digits_bound", 32'(n < 3 * FRAME), 32'd1);
  endtask

  initial begin
    int n;
    resetn      = 1'b0;
    enable      = 1'b0;
    load_valid  = 1'b0;
    load_digits = '0;
    step(2);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    check("rst_digits", 32'(digits_out), 32'h0);
    check("rst_ready", 32'(load_ready), 32'd1);

    // Startup latency and frame period.
    enable = 1'b1;
    step(2);
    @(negedge CLOCK_50);
    check("blank_gap", 32'(row_active), 32'd0);
    step(1);
    @(negedge CLOCK_50);
    check("first_active", 32'(row_active), 32'd1);
    check("first_fs", 32'(frame_start), 32'd1);
    step(23);
    @(negedge CLOCK_50);
    check("fs_gap", 32'(frame_start), 32'd0);
    step(1);
    @(negedge CLOCK_50);
    check("fs_period", 32'(frame_start), 32'd1);

    // Load while idle: swapped on the following edge.
    enable = 1'b0;
    step(1);
    load_valid  = 1'b1;
    load_digits = 16'h1234;
    step(1);
    load_valid = 1'b0;
    @(negedge CLOCK_50);
    check("idle_ready_low", 32'(load_ready), 32'd0);
    step(1);
    @(negedge CLOCK_50);
    check("idle_swap", 32'(digits_out), 32'h1234);
    check("idle_ready_back", 32'(load_ready), 32'd1);

    // Load mid-frame, then a second load while full.
    enable = 1'b1;
    wait_row(1);
    load_valid  = 1'b1;
    load_digits = 16'hABCD;
    step(1);
    load_digits = 16'h5555;
    @(negedge CLOCK_50);
    check("full_ready_low", 32'(load_ready), 32'd0);
    check("no_tear", 32'(digits_out), 32'h1234);
    wait_digits(16'hABCD, n);
    @(negedge CLOCK_50);
    check("swap_row", 32'(cur_row), 32'd0);
    check("swap_ready", 32'(load_ready), 32'd1);
    step(1);
    load_valid = 1'b0;
    @(negedge CLOCK_50);
    check("second_accept", 32'(load_ready), 32'd0);
    step(1);
    @(negedge CLOCK_50);
    check("fs_after_swap", 32'(frame_start), 32'd1);
    wait_digits(16'h5555, n);
    check("second_frame_delay", 32'(n), 32'd22);

    // Drop enable during row 2.
    wait_row(2);
    enable = 1'b0;
    step(1);
    @(negedge CLOCK_50);
    check("dis_active", 32'(row_active), 32'd0);
    check("dis_row", 32'(cur_row), 32'd0);
    check("dis_digits", 32'(digits_out), 32'h5555);
    enable = 1'b1;
    step(2);
    @(negedge CLOCK_50);
    check("reen_blank", 32'(row_active), 32'd0);
    step(1);
    @(negedge CLOCK_50);
    check("reen_active", 32'(row_active), 32'd1);

    // Reset while pending is full discards the pending data.
    load_valid  = 1'b1;
    load_digits = 16'h7777;
    step(1);
    load_valid = 1'b0;
    @(negedge CLOCK_50);
    check("pre_rst_full", 32'(load_ready), 32'd0);
    step(2);
    resetn = 1'b0;
    step(1);
    @(negedge CLOCK_50);
    check("mid_rst_digits", 32'(digits_out), 32'h0);
    check("mid_rst_ready", 32'(load_ready), 32'd0);
    check("mid_rst_active", 32'(row_active), 32'd0);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    check("post_rst_ready", 32'(load_ready), 32'd1);
    step(FRAME + 4);
    @(negedge CLOCK_50);
    check("pending_lost", 32'(digits_out), 32'h0);

    // Randomized traffic; the requester holds data until the model saw it accepted.
    for (int i = 0; i < 3000; i++) begin
      step(1);
      resetn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if (!(load_valid && !m_acc && resetn)) begin
        load_valid  = ($urandom_range(0, 9) == 0);
        load_digits = 16'($urandom);
      end
    end
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
